fir6_tap_datapath: RTL and testbench



---
 rtl/fir6_tap_datapath.sv | 94 +++++++++
 tb/tb_fir6_tap_datapath.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fir6_tap_datapath.sv
// Six-tap signed FIR datapath with a two-stage pipeline: registered products, then registered sum.
// Define FIR_APPROX_EN to round each product to a multiple of 2^APPROX_BITS before summing.
module fir6_tap_datapath #(
    parameter logic signed [31:0] C1          = 32'sd3,
    parameter logic signed [31:0] C2          = -32'sd5,
    parameter logic signed [31:0] C3          = 32'sd7,
    parameter logic signed [31:0] C4          = 32'sd7,
    parameter logic signed [31:0] C5          = -32'sd5,
    parameter logic signed [31:0] C6          = 32'sd3,
    parameter int unsigned        APPROX_BITS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic signed [31:0] in_1_0,
    input  logic signed [31:0] in_2_0,
    input  logic signed [31:0] in_3_0,
    input  logic signed [31:0] in_4_0,
    input  logic signed [31:0] in_5_0,
    input  logic signed [31:0] in_6_0,
    output logic               out_valid,
    output logic signed [31:0] out_11
);

`ifdef FIR_APPROX_EN
    localparam bit APPROX_EN = 1'b1;
`else
    localparam bit APPROX_EN = 1'b0;
`endif

    localparam logic signed [31:0] COEF [6] = '{C1, C2, C3, C4, C5, C6};
    localparam logic [31:0] ROUND_ADD  = 32'd1 << (APPROX_BITS - 1);
    localparam logic [31:0] ROUND_MASK = ~((32'd1 << APPROX_BITS) - 32'd1);

    logic signed [31:0] tap    [6];
    logic signed [31:0] prod_d [6];
    logic signed [31:0] prod_q [6];
    logic signed [31:0] sum_d;
    logic               v1_q;
    logic               out_valid_q;
    logic signed [31:0] out_q;

    always_comb begin
        tap[0] = in_1_0;
        tap[1] = in_2_0;
        tap[2] = in_3_0;
        tap[3] = in_4_0;
        tap[4] = in_5_0;
        tap[5] = in_6_0;
    end

    // A 32-bit context keeps only the low 32 bits of each product (two's-complement wrap).
    always_comb begin
        for (int k = 0; k < 6; k++) begin
            prod_d[k] = tap[k] * COEF[k];
            if (APPROX_EN) begin
                prod_d[k] = (prod_d[k] + ROUND_ADD) & ROUND_MASK;
            end
        end
    end

    always_comb begin
        // NOTE: assign a default before any accumulation so every path drives sum_d and no latch is inferred.
        sum_d = '0;
        for (int k = 0; k < 6; k++) begin
            sum_d = sum_d + prod_q[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the product array is reset element-wise; this is a small register bank, not a RAM,
            // and a mid-pipeline reset must leave no stale product behind.
            prod_q      <= '{default: '0};
            v1_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            // NOTE: non-blocking updates let both stages read the pre-edge value of v1_q/prod_q.
            v1_q        <= in_valid;
            out_valid_q <= v1_q;
            if (in_valid) begin
                prod_q <= prod_d;
            end
            if (v1_q) begin
                out_q <= sum_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_11    = out_q;

endmodule

// File: tb/tb_fir6_tap_datapath.sv
// Self-checking bench for fir6_tap_datapath: directed literals, mid-stream reset, random streaming
// compared every cycle against a plain-arithmetic reference model.
module tb_fir6_tap_datapath;

`ifdef FIR_APPROX_EN
    localparam bit APPROX = 1'b1;
`else
    localparam bit APPROX = 1'b0;
`endif
    localparam int AB = 4;
    localparam int COEF [6] = '{3, -5, 7, 7, -5, 3};

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic [5:0][31:0]  taps;
    logic              out_valid;
    logic [31:0]       out_11;

    int checks = 0;
    int errors = 0;

    fir6_tap_datapath dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_1_0    (taps[0]),
        .in_2_0    (taps[1]),
        .in_3_0    (taps[2]),
        .in_4_0    (taps[3]),
        .in_5_0    (taps[4]),
        .in_6_0    (taps[5]),
        .out_valid (out_valid),
        .out_11    (out_11)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: each product is the true integer product truncated to 32 bits, optionally rounded.
    function automatic logic [31:0] fir_ref(input logic [5:0][31:0] t, input bit approx);
        longint      acc;
        longint      full;
        logic [31:0] p;
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            full = longint'($signed(t[k])) * longint'(COEF[k]);
            p    = full[31:0];
            if (approx) begin
                p = (p + 32'(1 << (AB - 1))) & ~32'((1 << AB) - 1);
            end
            acc = acc + longint'($signed(p));
        end
        return acc[31:0];
    endfunction

    // Model state: a vector accepted at one edge is visible on the outputs after the next edge.
    bit          pend_v;
    logic [31:0] pend_val;
    logic [31:0] pend_exact;
    bit          exp_valid;
    logic [31:0] exp_out;
    longint      err_sum;
    int          err_n;
    int          err_max;

    initial begin
        err_sum = 0;
        err_n   = 0;
        err_max = 0;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_v    = 1'b0;
            exp_valid = 1'b0;
            exp_out   = '0;
        end else begin
            exp_valid = pend_v;
            if (pend_v) begin
                int e;
                exp_out = pend_val;
                e       = int'($signed(pend_val - pend_exact));
                err_sum = err_sum + longint'(e);
                err_n++;
                if (e < 0) e = -e;
                if (e > err_max) err_max = e;
            end
            pend_v = in_valid;
            if (in_valid) begin
                pend_val   = fir_ref(taps, APPROX);
                pend_exact = fir_ref(taps, 1'b0);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("cmp_out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
            check("cmp_out_11", out_11, exp_out);
        end
    end

    task automatic junk_taps();
        for (int k = 0; k < 6; k++) taps[k] = $urandom;
    endtask

    // Present one vector from idle and pin both the DUT and the model to a hand-computed value.
    task automatic send_one(input string name, input logic [5:0][31:0] t, input logic [31:0] exp_lit);
        @(negedge clk);
        taps     = t;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        junk_taps();
        check({name, "_early"}, {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check({name, "_valid"}, {31'd0, out_valid}, 32'd1);
        check(name, out_11, exp_lit);
        check({name, "_model"}, fir_ref(t, APPROX), exp_lit);
    endtask

    int imp_exp [6];
    logic [5:0][31:0] t;
    logic [5:0][31:0] line;

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        taps     = '0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_11", out_11, 32'd0);
        #2 rst_n = 1'b1;

        // Impulse through each tap.
        if (APPROX) imp_exp = '{0, 0, 0, 0, 0, 0};
        else        imp_exp = '{3, -5, 7, 7, -5, 3};
        for (int k = 0; k < 6; k++) begin
            t    = '0;
            t[k] = 32'd1;
            send_one($sformatf("impulse_tap%0d", k + 1), t, 32'(imp_exp[k]));
        end

        // DC levels.
        t = {6{32'd100}};
        send_one("dc_100", t, APPROX ? 32'd1024 : 32'd1000);
        t = {6{32'd4095}};
        send_one("dc_4095", t, APPROX ? 32'd40960 : 32'd40950);

        // Wrap-around products.
        t = '0; t[0] = 32'h7FFF_FFFF;
        send_one("wrap_max", t, APPROX ? 32'h8000_0000 : 32'h7FFF_FFFD);
        t = '0; t[1] = 32'h8000_0000;
        send_one("wrap_min", t, 32'h8000_0000);

        // Product rounding on small values.
        t = '0; t[0] = 32'd5;
        send_one("round_5", t, APPROX ? 32'd16 : 32'd15);
        t = '0; t[0] = 32'd2;
        send_one("round_2", t, APPROX ? 32'd0 : 32'd6);

        // Mid-stream reset: fill the pipeline, then reset with results in flight.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            for (int k = 0; k < 6; k++) taps[k] = 32'($urandom_range(1, 4095));
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_out_11", out_11, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_idle", {31'd0, out_valid}, 32'd0);
        end
        t = {6{32'd100}};
        send_one("post_rst_first", t, APPROX ? 32'd1024 : 32'd1000);

        // Streaming with random gaps; the compare process checks every cycle.
        err_sum = 0;
        err_n   = 0;
        err_max = 0;
        line    = '0;
        for (int n = 0; n < 1000; ) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                junk_taps();
            end else begin
                line[5:1] = line[4:0];
                line[0]   = 32'($urandom_range(0, 4095));
                taps      = line;
                in_valid  = 1'b1;
                n++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);

        check("stream_count", 32'(err_n), 32'd1000);
        if (APPROX) begin
            check("stream_err_bound", {31'd0, err_max <= 48}, 32'd1);
            check("stream_err_mean", {31'd0, (err_sum <= 8 * 1000) && (err_sum >= -8 * 1000)}, 32'd1);
        end else begin
            check("stream_err_max", 32'(err_max), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
